bcd_scan_display: RTL

BCD_SCAN_DISPLAY -- requirements
Module: bcd_scan_display

---
 rtl/bcd_scan_display.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/bcd_scan_display.sv
// Multiplexed seven-segment BCD display driver: shadow-registered digits, time-sliced
// digit scan, leading-zero blanking, frame-synchronous blinking and registered outputs.
module bcd_scan_display #(
    parameter int NUM_DIGITS     = 4,
    parameter int SCAN_DIV       = 1000,
    parameter int BLINK_FRAMES   = 64,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int BLANK_LZ       = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    input  logic                    blink_en,
    output logic [7:1]              seven,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic                    frame_done
);

    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PW = $clog2(SCAN_DIV);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);
    // Inactive output levels; XOR with these converts the active-high view at the register.
    localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic       DP_OFF  = (SEG_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    // Active-high segment pattern, bit 6 = g down to bit 0 = a; non-BCD codes are blank.
    function automatic logic [6:0] seg_decode(input logic [3:0] value);
        logic [6:0] seg;
        case (value)
            4'd0:    seg = 7'b0111111;
            4'd1:    seg = 7'b0000110;
            4'd2:    seg = 7'b1011011;
            4'd3:    seg = 7'b1001111;
            4'd4:    seg = 7'b1100110;
            4'd5:    seg = 7'b1101101;
            4'd6:    seg = 7'b1111101;
            4'd7:    seg = 7'b0000111;
            4'd8:    seg = 7'b1111111;
            4'd9:    seg = 7'b1101111;
            default: seg = 7'b0000000;
        endcase
        return seg;
    endfunction

    logic [4*NUM_DIGITS-1:0] bcd_q, bcd_d;
    logic [NUM_DIGITS-1:0]   dpr_q, dpr_d;
    logic [PW-1:0]           presc_q, presc_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [FW-1:0]           frame_cnt_q, frame_cnt_d;
    logic                    blink_on_q, blink_on_d;
    logic [6:0]              seven_q, seven_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   digit_en_q, digit_en_d;
    logic                    frame_done_q, frame_done_d;

    logic                    presc_wrap_s;
    logic                    frame_evt_s;
    logic                    show_s;
    logic                    upper_zero_s;
    logic [3:0]              cur_digit_s;
    logic                    cur_dp_s;
    logic                    cur_blank_s;
    logic [NUM_DIGITS-1:0]   onehot_s;

    // Next-state: shadow capture, prescaler, digit index and blink phase.
    always_comb begin
        bcd_d        = load ? bcd_in : bcd_q;
        dpr_d        = load ? dp_in  : dpr_q;
        presc_wrap_s = (presc_q == PRESC_LAST);
        frame_evt_s  = presc_wrap_s && (idx_q == IDX_LAST);
        presc_d      = presc_wrap_s ? '0 : presc_q + PW'(1);
        idx_d        = idx_q;
        frame_cnt_d  = frame_cnt_q;
        blink_on_d   = blink_on_q;
        if (presc_wrap_s) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
        end else begin
            idx_d = idx_q;
        end
        if (!blink_en) begin
            frame_cnt_d = '0;
            blink_on_d  = 1'b1;
        end else if (frame_evt_s) begin
            if (frame_cnt_q == FRAME_LAST) begin
                frame_cnt_d = '0;
                blink_on_d  = !blink_on_q;
            end else begin
                frame_cnt_d = frame_cnt_q + FW'(1);
            end
        end else begin
            frame_cnt_d = frame_cnt_q;
        end
    end

    // Output next-state: select the active digit and apply blanking, blink and polarity.
    always_comb begin
        upper_zero_s = 1'b1;
        cur_digit_s  = 4'd0;
        cur_dp_s     = 1'b0;
        cur_blank_s  = 1'b0;
        onehot_s     = '0;
        // Walk from the most significant digit so upper_zero_s covers digit i and above.
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            upper_zero_s = upper_zero_s && (bcd_q[4*i +: 4] == 4'd0);
            onehot_s[i]  = (idx_q == IW'(i));
            if (idx_q == IW'(i)) begin
                cur_digit_s = bcd_q[4*i +: 4];
                cur_dp_s    = dpr_q[i];
                cur_blank_s = (BLANK_LZ != 0) && (i != 0) && upper_zero_s;
            end else begin
                cur_digit_s = cur_digit_s;
            end
        end
        show_s       = !(blink_en && !blink_on_q);
        seven_d      = ((show_s && !cur_blank_s) ? seg_decode(cur_digit_s) : 7'd0) ^ SEG_OFF;
        dp_d         = (show_s && cur_dp_s) ^ DP_OFF;
        digit_en_d   = show_s ? onehot_s : '0;
        frame_done_d = frame_evt_s;
    end

    // State and output registers with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            bcd_q        <= '0;
            dpr_q        <= '0;
            presc_q      <= '0;
            idx_q        <= '0;
            frame_cnt_q  <= '0;
            blink_on_q   <= 1'b1;
            seven_q      <= SEG_OFF;
            dp_q         <= DP_OFF;
            digit_en_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            bcd_q        <= bcd_d;
            dpr_q        <= dpr_d;
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            frame_cnt_q  <= frame_cnt_d;
            blink_on_q   <= blink_on_d;
            seven_q      <= seven_d;
            dp_q         <= dp_d;
            digit_en_q   <= digit_en_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seven      = seven_q;
    assign dp         = dp_q;
    assign digit_en   = digit_en_q;
    assign frame_done = frame_done_q;

endmodule
